i2c_req_arbiter: RTL

Round-robin arbiter and sequencer that shares one I2C transaction engine (the byte-level master driving `gpdi_sda`/`gpdi_scl`) among `NREQ` requesters, for example the DDC/EDID reader and the HDMI config walker.
- Accepts one register-level request (device address, register address, read/write, write data) at a time.
- Issues the request to the engine, retries on NACK and enforces a busy timeout.
- Returns read data and a status code to the granted requester.
- Sits between the engine and the system logic in `SystemConnect`, in the `clk_4MHz` domain.

---
 rtl/i2c_arb_pkg.sv | 15 +
 rtl/i2c_req_arbiter_rr_pick.sv | 27 ++
 rtl/i2c_req_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/i2c_arb_pkg.sv
// i2c_arb_pkg: shared types for the I2C request arbiter
package i2c_arb_pkg;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RETRY, RESP} arb_state_t;
  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_NACK    = 2'b01,
    ERR_TIMEOUT = 2'b10
  } i2c_err_t;
  typedef struct packed {
    logic       rw;
    logic [6:0] dev;
    logic [7:0] reg_addr;
    logic [7:0] wdata;
  } i2c_req_t;
endpackage

// File: rtl/i2c_req_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first request above last grant wins
module rr_pick #(
  parameter int NREQ = 4,
  localparam int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);
  logic [IW-1:0] k;
  // Walk offsets from farthest to nearest so the nearest requester overwrites.
  always_comb begin
    gnt = '0;
    idx = '0;
    k   = '0;
    for (int i = NREQ; i >= 1; i--) begin
      k = IW'((int'(last) + i) % NREQ);
      if (req[k]) begin
        gnt = NREQ'(1) << k;
        idx = k;
      end
    end
  end
  assign any = |req;
endmodule

// File: rtl/i2c_req_arbiter.sv
// i2c_req_arbiter: round-robin sequencer sharing one I2C engine with retry and timeout
module i2c_req_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int MAX_RETRY   = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                     clk_4MHz,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_rw,
  input  logic [NREQ*7-1:0]        req_dev,
  input  logic [NREQ*8-1:0]        req_reg,
  input  logic [NREQ*8-1:0]        req_wdata,
  output logic [NREQ-1:0]          req_ready,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [7:0]               rsp_rdata,
  output logic [1:0]               rsp_err,
  output logic                     eng_start,
  output logic                     eng_rw,
  output logic [6:0]               eng_dev,
  output logic [7:0]               eng_reg,
  output logic [7:0]               eng_wdata,
  input  logic                     eng_busy,
  input  logic                     eng_done,
  input  logic                     eng_nack,
  input  logic [7:0]               eng_rdata,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     busy
);
  localparam int IW = $clog2(NREQ);
  localparam int TW = $clog2(TIMEOUT_CYC);

  arb_state_t      state_q, state_d;
  i2c_req_t        cmd_q, cmd_d;
  i2c_err_t        err_q, err_d;
  logic [IW-1:0]   gid_q, gid_d, last_q, last_d, pick_idx;
  logic [2:0]      retry_q, retry_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [NREQ-1:0] rdy_q, rdy_d, rspv_q, rspv_d, pick_gnt;
  logic [7:0]      rdata_q, rdata_d;
  logic            pick_any;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req  (req_valid),
    .last (last_q),
    .gnt  (pick_gnt),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    gid_d   = gid_q;
    last_d  = last_q;
    retry_d = retry_q;
    timer_d = timer_q;
    rdy_d   = '0;
    rspv_d  = '0;
    rdata_d = '0;
    err_d   = ERR_OK;
    case (state_q)
      IDLE: if (pick_any) begin
        cmd_d   = '{rw:       req_rw[pick_idx],
                    dev:      7'(req_dev >> (7 * pick_idx)),
                    reg_addr: 8'(req_reg >> (8 * pick_idx)),
                    wdata:    8'(req_wdata >> (8 * pick_idx))};
        gid_d   = pick_idx;
        retry_d = '0;
        rdy_d   = pick_gnt;
        state_d = ISSUE;
      end
      ISSUE: if (!eng_busy) begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A completion in the timeout cycle still counts as a completion.
        if (eng_done && !eng_nack) begin
          rdata_d = cmd_q.rw ? eng_rdata : 8'h00;
          rspv_d  = NREQ'(1) << gid_q;
          state_d = RESP;
        end else if (eng_done && retry_q < 3'(MAX_RETRY)) begin
          retry_d = retry_q + 3'd1;
          state_d = RETRY;
        end else if (eng_done) begin
          err_d   = ERR_NACK;
          rspv_d  = NREQ'(1) << gid_q;
          state_d = RESP;
        end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
          err_d   = ERR_TIMEOUT;
          rspv_d  = NREQ'(1) << gid_q;
          state_d = RESP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      RETRY: state_d = eng_busy ? RETRY : ISSUE;
      RESP: begin
        last_d  = gid_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_4MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      err_q   <= ERR_OK;
      gid_q   <= '0;
      last_q  <= IW'(NREQ - 1);
      retry_q <= '0;
      timer_q <= '0;
      rdy_q   <= '0;
      rspv_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      err_q   <= err_d;
      gid_q   <= gid_d;
      last_q  <= last_d;
      retry_q <= retry_d;
      timer_q <= timer_d;
      rdy_q   <= rdy_d;
      rspv_q  <= rspv_d;
      rdata_q <= rdata_d;
    end
  end

  assign req_ready = rdy_q;
  assign rsp_valid = rspv_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign eng_start = (state_q == ISSUE) && !eng_busy;
  assign eng_rw    = cmd_q.rw;
  assign eng_dev   = cmd_q.dev;
  assign eng_reg   = cmd_q.reg_addr;
  assign eng_wdata = cmd_q.wdata;
  assign grant_id  = gid_q;
  assign busy      = state_q != IDLE;
endmodule
